// File: rtl/rng_pkg.sv
// Shared constants, state encoding and helpers for the rng enable/valid link and its consumers.
package rng_pkg;

  localparam int RNG_W    = 3456;
  localparam int M0_LSB   = 0;
  localparam int M0_MSB   = 255;
  localparam int M1_LSB   = 256;
  localparam int M1_MSB   = 511;
  localparam int RW_LSB   = 512;
  localparam int RW_MSB   = 943;
  localparam int CNT_W    = 3;
  localparam int TMR_W    = 8;
  localparam int REFILL_W = 16;

  typedef enum logic [1:0] {
    FT_IDLE = 2'd0,
    FT_REQ  = 2'd1,
    FT_WAIT = 2'd2
  } fetch_state_e;

  // Capture counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [REFILL_W-1:0] sat_inc(input logic [REFILL_W-1:0] v);
    return (v == {REFILL_W{1'b1}}) ? v : v + REFILL_W'(1);
  endfunction

endpackage

// File: rtl/rng_mask_fetcher_if.sv
// rng-side enable/valid link plus the consumer-side valid/ready head-of-buffer bus.
interface rng_mask_fetcher_if #(
  parameter int WIDTH = rng_pkg::RNG_W
);
  import rng_pkg::*;

  logic                     rng_enable_o;
  logic                     rng_valid_i;
  logic [WIDTH-1:0]         rng_rb_i;
  logic                     cons_valid_o;
  logic                     cons_ready_i;
  logic [M0_MSB-M0_LSB:0]   m0_o;
  logic [M1_MSB-M1_LSB:0]   m1_o;
  logic [RW_MSB-RW_LSB:0]   rw_o;
  logic [WIDTH-1:0]         rb_o;

  modport master (
    output rng_enable_o,
    input  rng_valid_i,
    input  rng_rb_i,
    output cons_valid_o,
    input  cons_ready_i,
    output m0_o,
    output m1_o,
    output rw_o,
    output rb_o
  );

  modport slave (
    input  rng_enable_o,
    output rng_valid_i,
    output rng_rb_i,
    input  cons_valid_o,
    output cons_ready_i,
    input  m0_o,
    input  m1_o,
    input  rw_o,
    input  rb_o
  );

endinterface

// File: rtl/rng_mask_fifo.sv
// DEPTH x WIDTH bundle buffer: every popped or flushed entry is overwritten with zero,
// and the head output is forced to zero whenever the buffer is empty.
module rng_mask_fifo
  import rng_pkg::*;
#(
  parameter int WIDTH = RNG_W,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [CNT_W-1:0] count_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;
  logic             w_push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? PW'(0) : p + PW'(1);
  endfunction

  assign w_pop  = pop_i & (r_count != CNT_W'(0));
  assign w_push = push_i & ((r_count < CNT_W'(DEPTH)) | w_pop);

  // Storage: the write follows the zeroize so that with DEPTH=1 the freed slot takes the new bundle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_pop)  r_mem[r_head] <= '0;
      if (w_push) r_mem[r_tail] <= din_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop)  r_head <= ptr_inc(r_head);
      if (w_push) r_tail <= ptr_inc(r_tail);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign count_o = r_count;
  assign valid_o = (r_count != CNT_W'(0));
  assign head_o  = valid_o ? r_mem[r_head] : '0;

endmodule

// File: rtl/rng_mask_fetcher.sv
// Consumer end of the rng enable/valid link: requests bundles, buffers them and hands each one
// to the masked core exactly once, zeroizing buffer slots as they are consumed.
module rng_mask_fetcher
  import rng_pkg::*;
#(
  parameter int                  WIDTH       = RNG_W,
  parameter int                  DEPTH       = 2,
  parameter int                  TIMEOUT     = 15,
  parameter logic [REFILL_W-1:0] REFILL_INIT = 16'h0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_en_i,
  input  logic                  flush_i,
  rng_mask_fetcher_if.master    bus,
  output logic [REFILL_W-1:0]   refill_cnt_o,
  output logic                  err_timeout_o
);

  fetch_state_e        r_state;
  fetch_state_e        w_state_nxt;
  logic [TMR_W-1:0]    r_timer;
  logic [REFILL_W-1:0] r_refill;
  logic                r_err;
  logic [CNT_W-1:0]    w_count;
  logic                w_space;
  logic                w_timeout;
  logic                w_capture;
  logic                w_timeout_evt;
  logic                w_pop;
  logic                w_head_valid;
  logic [WIDTH-1:0]    w_head;

  assign w_space   = (w_count < CNT_W'(DEPTH));
  assign w_timeout = ((r_timer + TMR_W'(1)) == TMR_W'(TIMEOUT));
  assign w_pop     = bus.cons_ready_i & w_head_valid & ~flush_i;

  // Next state; a request is only launched while a free slot exists, so a capture never overflows.
  always_comb begin
    w_state_nxt   = r_state;
    w_capture     = 1'b0;
    w_timeout_evt = 1'b0;
    if (flush_i) begin
      w_state_nxt = FT_IDLE;
    end else begin
      case (r_state)
        FT_IDLE: begin
          if (fetch_en_i && w_space) w_state_nxt = FT_REQ;
          else                       w_state_nxt = FT_IDLE;
        end
        FT_REQ: w_state_nxt = FT_WAIT;
        FT_WAIT: begin
          if (bus.rng_valid_i) begin
            w_state_nxt = FT_IDLE;
            w_capture   = 1'b1;
          end else if (w_timeout) begin
            w_state_nxt   = FT_REQ;
            w_timeout_evt = 1'b1;
          end else begin
            w_state_nxt = FT_WAIT;
          end
        end
        default: w_state_nxt = FT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= FT_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Wait timer counts cycles spent in WAIT; REQ always precedes WAIT so it restarts there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   r_timer <= '0;
    else if (r_state == FT_REQ)  r_timer <= '0;
    else if (r_state == FT_WAIT) r_timer <= r_timer + TMR_W'(1);
    else                         r_timer <= r_timer;
  end

  // Status: capture count survives flush, timeout flag does not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_refill <= REFILL_INIT;
      r_err    <= 1'b0;
    end else begin
      if (w_capture) r_refill <= sat_inc(r_refill);
      if (flush_i)            r_err <= 1'b0;
      else if (w_timeout_evt) r_err <= 1'b1;
    end
  end

  rng_mask_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (w_capture),
    .pop_i   (w_pop),
    .flush_i (flush_i),
    .din_i   (bus.rng_rb_i),
    .count_o (w_count),
    .valid_o (w_head_valid),
    .head_o  (w_head)
  );

  assign bus.rng_enable_o = (r_state == FT_REQ);
  assign bus.cons_valid_o = w_head_valid;
  assign bus.rb_o         = w_head;
  assign bus.m0_o         = w_head[M0_MSB:M0_LSB];
  assign bus.m1_o         = w_head[M1_MSB:M1_LSB];
  assign bus.rw_o         = w_head[RW_MSB:RW_LSB];
  assign refill_cnt_o     = r_refill;
  assign err_timeout_o    = r_err;

endmodule
